// File: rtl/uart_pkg.sv
// Shared definitions for the UART core family: receiver state encoding,
// frame width and the clocks-per-tick calculation used by both directions.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    function automatic int calc_divisor(input int clock_hz, input int baud, input int oversample);
        return clock_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIVISOR clocks,
// realigned to zero by restart so sampling can lock onto a start edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIVISOR = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // A restart cycle never ticks, so the first tick lands DIVISOR clocks later.
    always_comb begin
        count_d = count_q + CW'(1);
        tick    = 1'b0;
        if (restart) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
            tick    = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples each bit at mid-period and
// hands completed bytes to a consumer over a valid/ready handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ   = 16_000_000,
    parameter int BAUD       = 1_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 valid,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] data,
    output logic                 frame_error,
    output logic                 overrun
);

    localparam int DIVISOR = calc_divisor(CLOCK_HZ, BAUD, OVERSAMPLE);
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS);
    localparam logic [SW-1:0] MID_SAMPLE  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

    generate
        if (DIVISOR < 1) begin : g_divisor_check
            $error("uart_rx: CLOCK_HZ too low for BAUD*OVERSAMPLE");
        end
        if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_oversample_check
            $error("uart_rx: OVERSAMPLE must be even and >= 8");
        end
    endgenerate

    uart_rx_state_t       state_q, state_d;
    logic                 sync_q, rx_s_q;
    logic [SW-1:0]        sample_q, sample_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 frame_error_q, frame_error_d;
    logic                 overrun_q, overrun_d;
    logic                 restart, tick, mid, stop_mid, deliver;

    assign restart  = (state_q == IDLE) && !rx_s_q;
    assign mid      = tick && (sample_q == MID_SAMPLE);
    assign stop_mid = (state_q == STOP) && mid;
    assign deliver  = stop_mid && rx_s_q;

    uart_baud_tick #(
        .DIVISOR (DIVISOR)
    ) u_tick (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // BREAK holds off start detection until a held-low line returns high.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!rx_s_q) state_d = START;
            START:   if (mid) state_d = rx_s_q ? IDLE : DATA;
            DATA:    if (mid && (bit_idx_q == LAST_BIT)) state_d = STOP;
            STOP:    if (mid) state_d = rx_s_q ? IDLE : BREAK;
            BREAK:   if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sample_d      = sample_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        valid_d       = valid_q;
        data_d        = data_q;
        frame_error_d = stop_mid && !rx_s_q;
        overrun_d     = deliver && valid_q && !ready;

        if (restart) begin
            sample_d = '0;
        end else if (tick) begin
            sample_d = (sample_q == LAST_SAMPLE) ? '0 : sample_q + SW'(1);
        end

        if ((state_q == START) && mid) begin
            bit_idx_d = '0;
        end
        if ((state_q == DATA) && mid) begin
            shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + BW'(1);
        end

        // Same-cycle accept and load keeps valid high with the new byte.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (deliver && (!valid_q || ready)) begin
            valid_d = 1'b1;
            data_d  = shift_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q        <= 1'b1;
            rx_s_q        <= 1'b1;
            sample_q      <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            valid_q       <= 1'b0;
            data_q        <= '0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sync_q        <= rx;
            rx_s_q        <= sync_q;
            sample_q      <= sample_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign valid       = valid_q;
    assign data        = data_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized serial frames against a byte-queue reference of
// what a correct 8N1 receiver must hand to its consumer.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam realtime HALF_NS = 31.25;
    localparam realtime BIT_NS  = 1000.0;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b1;
    logic       valid;
    logic [7:0] data;
    logic       frame_error;
    logic       overrun;

    int asserts   = 0;
    int fails     = 0;
    int cyc       = 0;
    int rise_cyc  = -1;
    int start_cyc = 0;
    int fe_cnt    = 0;
    int ov_cnt    = 0;
    int valid_cnt = 0;
    int fe0, ov0, v0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic       hold_prev  = 1'b0;
    logic       valid_prev = 1'b0;
    logic [7:0] data_prev  = 8'h00;

    uart_rx dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .valid       (valid),
        .ready       (ready),
        .data        (data),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    always #(HALF_NS) clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        asserts++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // One 8N1 frame, LSB first; the line is left at the stop level afterwards.
    task automatic applyStimulus(input logic [7:0] b, input realtime bit_t, input logic stop_v);
        start_cyc = cyc;
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_t);
        end
        rx = stop_v;
        #(bit_t);
    endtask

    task automatic check_bytes(input string tag);
        checkOutput({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while ((got_q.size() > 0) && (exp_q.size() > 0)) begin
            checkOutput({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic mark();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        v0  = valid_cnt;
    endtask

    // Consumer side: records accepted bytes, pulses, and checks that an
    // unaccepted byte stays presented unchanged.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            if (hold_prev) begin
                checkOutput("hold_valid", 32'(valid), 32'(1));
                checkOutput("hold_data", 32'(data), 32'(data_prev));
            end
            if (valid && ready) got_q.push_back(data);
            if (valid && !valid_prev) rise_cyc = cyc;
            if (valid) valid_cnt++;
            if (frame_error) fe_cnt++;
            if (overrun) ov_cnt++;
        end
        hold_prev  = reset && valid && !ready;
        valid_prev = valid;
        data_prev  = data;
    end

    initial begin
        #(2ms);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] b;
        realtime    bt;
        int         gap;
        logic [7:0] part;

        repeat (4) @(negedge clock);
        checkOutput("rst_valid", 32'(valid), 32'(0));
        checkOutput("rst_data", 32'(data), 32'(0));
        checkOutput("rst_fe", 32'(frame_error), 32'(0));
        checkOutput("rst_ov", 32'(overrun), 32'(0));
        @(posedge clock); #1 reset = 1'b1;
        repeat (10) @(posedge clock);

        mark();
        rise_cyc = -1;
        applyStimulus(8'hA5, BIT_NS, 1'b1);
        exp_q.push_back(8'hA5);
        #(2 * BIT_NS);
        check_bytes("a5");
        checkOutput("a5_latency", 32'((rise_cyc - start_cyc >= 150) && (rise_cyc - start_cyc <= 160)), 32'(1));
        checkOutput("a5_valid_cycles", 32'(valid_cnt - v0), 32'(1));
        checkOutput("a5_fe", 32'(fe_cnt - fe0), 32'(0));
        checkOutput("a5_ov", 32'(ov_cnt - ov0), 32'(0));

        mark();
        @(posedge clock); #1 ready = 1'b0;
        applyStimulus(8'h3C, BIT_NS, 1'b1);
        applyStimulus(8'h81, BIT_NS, 1'b1);
        #(2 * BIT_NS);
        @(negedge clock);
        checkOutput("bp_valid", 32'(valid), 32'(1));
        checkOutput("bp_data", 32'(data), 32'h3C);
        checkOutput("bp_ov", 32'(ov_cnt - ov0), 32'(1));
        checkOutput("bp_fe", 32'(fe_cnt - fe0), 32'(0));
        @(posedge clock); #1 ready = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("bp_valid_fall", 32'(valid), 32'(0));
        exp_q.push_back(8'h3C);
        check_bytes("bp");

        mark();
        applyStimulus(8'h55, BIT_NS, 1'b0);
        #(40 * BIT_NS);
        checkOutput("brk_fe", 32'(fe_cnt - fe0), 32'(1));
        checkOutput("brk_valid", 32'(valid_cnt - v0), 32'(0));
        check_bytes("brk");
        rx = 1'b1;
        #(2 * BIT_NS);
        applyStimulus(8'h0F, BIT_NS, 1'b1);
        exp_q.push_back(8'h0F);
        #(2 * BIT_NS);
        check_bytes("brk_after");
        checkOutput("brk_fe_once", 32'(fe_cnt - fe0), 32'(1));

        mark();
        @(posedge clock); #1 rx = 1'b0;
        repeat (4) @(posedge clock);
        #1 rx = 1'b1;
        #(2 * BIT_NS);
        check_bytes("glitch");
        checkOutput("glitch_valid", 32'(valid_cnt - v0), 32'(0));
        checkOutput("glitch_fe", 32'(fe_cnt - fe0), 32'(0));

        mark();
        applyStimulus(8'h00, BIT_NS * 1.03, 1'b1);
        applyStimulus(8'hFF, BIT_NS * 0.97, 1'b1);
        applyStimulus(8'h5A, BIT_NS * 1.03, 1'b1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h5A);
        #(2 * BIT_NS);
        check_bytes("loop");

        for (int n = 0; n < 12; n++) begin
            b   = 8'($urandom_range(0, 255));
            bt  = BIT_NS * (1.0 + real'(int'($urandom_range(0, 40)) - 20) / 1000.0);
            gap = int'($urandom_range(0, 2));
            applyStimulus(b, bt, 1'b1);
            exp_q.push_back(b);
            if (gap > 0) #(gap * BIT_NS);
        end
        #(2 * BIT_NS);
        check_bytes("rand");
        checkOutput("rand_fe", 32'(fe_cnt - fe0), 32'(0));
        checkOutput("rand_ov", 32'(ov_cnt - ov0), 32'(0));

        mark();
        part = 8'h96;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = part[i];
            #(BIT_NS);
        end
        rx = part[4];
        #(BIT_NS / 2);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(valid), 32'(0));
        checkOutput("mid_rst_data", 32'(data), 32'(0));
        checkOutput("mid_rst_fe", 32'(frame_error), 32'(0));
        checkOutput("mid_rst_ov", 32'(overrun), 32'(0));
        rx = 1'b1;
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        #(2 * BIT_NS);
        applyStimulus(8'hC3, BIT_NS, 1'b1);
        exp_q.push_back(8'hC3);
        #(2 * BIT_NS);
        check_bytes("mid_rst");
        checkOutput("mid_rst_fe_cnt", 32'(fe_cnt - fe0), 32'(0));
        checkOutput("mid_rst_ov_cnt", 32'(ov_cnt - ov0), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
